spi_slave_cmd_decoder: RTL



---
 rtl/spi_slave_cmd_decoder.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_cmd_decoder.sv
// rtl/spi_slave_cmd_decoder.sv - SPI mode-0 slave command decoder for motor duty, enable and hall access; optional watchdog via SPI_CMD_WATCHDOG_EN
module spi_slave_cmd_decoder #(
    parameter int         NUM_MOTORS = 5,
    parameter int         DUTY_WIDTH = 11,
    parameter logic [7:0] STATUS_ID  = 8'hA5,
    parameter int         WDT_CYCLES = 2000000
) (
    input  logic                             sysclk,
    input  logic                             rst,
    input  logic                             spi_sck,
    input  logic                             spi_mosi,
    input  logic                             spi_ncs,
    output logic                             spi_miso,
    input  logic [NUM_MOTORS*16-1:0]         enc_cnt,
    input  logic [NUM_MOTORS*8-1:0]          hall_cnt,
    output logic [NUM_MOTORS*DUTY_WIDTH-1:0] duty,
    output logic                             motors_en,
    output logic [NUM_MOTORS-1:0]            hall_wr,
    output logic [7:0]                       hall_wr_val,
    output logic                             frame_done
);
    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_CMD, ST_DATA} state_t;

    localparam int NB = 2 * NUM_MOTORS;

    state_t                           r_state, w_state_nxt;
    logic [1:0]                       r_sck_s, r_mosi_s, r_ncs_s;
    logic                             r_sck_d, r_ncs_d;
    logic [2:0]                       r_bit_cnt;
    logic [6:0]                       r_rx_sh;
    logic [7:0]                       r_tx_sh;
    logic [7:0]                       r_cmd;
    logic [7:0]                       r_data_cnt;
    logic [7:0]                       r_duty_lo;
    logic [NUM_MOTORS*16-1:0]         r_enc_sh;
    logic [NUM_MOTORS*8-1:0]          r_hall_sh;
    logic [NUM_MOTORS*DUTY_WIDTH-1:0] r_duty_sh, r_duty;
    logic                             r_motors_en;
    logic [NUM_MOTORS-1:0]            r_hall_wr;
    logic [7:0]                       r_hall_wr_val;
    logic                             r_frame_done;

    logic        w_ncs, w_mosi, w_ncs_fall, w_in_frame, w_active;
    logic        w_sck_rise, w_sck_fall, w_byte_done, w_commit, w_hall_en, w_wdt_fire;
    logic [7:0]  w_rx_byte, w_status, w_cur_cmd, w_tx_idx, w_tx_byte;
    logic [15:0] w_duty_word;

    assign w_ncs       = r_ncs_s[1];
    assign w_mosi      = r_mosi_s[1];
    assign w_ncs_fall  = r_ncs_d & ~w_ncs;
    assign w_in_frame  = (r_state == ST_CMD) || (r_state == ST_DATA);
    assign w_active    = w_in_frame & ~w_ncs;
    assign w_sck_rise  = w_active & r_sck_s[1] & ~r_sck_d;
    assign w_sck_fall  = w_active & ~r_sck_s[1] & r_sck_d;
    assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
    assign w_rx_byte   = {r_rx_sh, w_mosi};
    assign w_status    = {STATUS_ID[7:1], r_motors_en};
    assign w_duty_word = {w_rx_byte, r_duty_lo};
    // The byte queued at the end of the command byte must already see the new command
    assign w_cur_cmd   = (r_state == ST_CMD) ? w_rx_byte : r_cmd;
    assign w_tx_idx    = (r_state == ST_CMD) ? 8'd0 : r_data_cnt + 8'd1;
    assign w_commit    = w_byte_done && (r_state == ST_DATA) && (r_cmd[6:0] == 7'h00)
                         && r_data_cnt[0] && (r_data_cnt[7:1] < 7'(NUM_MOTORS));
    assign w_hall_en   = w_byte_done && (r_state == ST_DATA) && (r_cmd == 8'h12)
                         && (r_data_cnt < 8'(NUM_MOTORS));

    assign spi_miso    = w_in_frame ? r_tx_sh[7] : 1'b0;
    assign duty        = r_duty;
    assign motors_en   = r_motors_en;
    assign hall_wr     = r_hall_wr;
    assign hall_wr_val = r_hall_wr_val;
    assign frame_done  = r_frame_done;

    // Two-flop synchronisers plus one delayed copy for edge detection; ncs resets low so SYNC waits for a real high
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_sck_s  <= 2'b00;
            r_mosi_s <= 2'b00;
            r_ncs_s  <= 2'b00;
            r_sck_d  <= 1'b0;
            r_ncs_d  <= 1'b0;
        end else begin
            r_sck_s  <= {r_sck_s[0], spi_sck};
            r_mosi_s <= {r_mosi_s[0], spi_mosi};
            r_ncs_s  <= {r_ncs_s[0], spi_ncs};
            r_sck_d  <= r_sck_s[1];
            r_ncs_d  <= w_ncs;
        end
    end

    // Frame state register
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) r_state <= ST_SYNC;
        else     r_state <= w_state_nxt;
    end

    // Frame state transitions
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SYNC: if (w_ncs) w_state_nxt = ST_IDLE;
            ST_IDLE: if (w_ncs_fall) w_state_nxt = ST_CMD;
            ST_CMD:  if (w_ncs) w_state_nxt = ST_IDLE;
                     else if (w_byte_done) w_state_nxt = ST_DATA;
            ST_DATA: if (w_ncs) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_SYNC;
        endcase
    end

    // Next TX byte: readback tables are served from the frame-start snapshots only
    always_comb begin
        w_tx_byte = 8'h00;
        for (int i = 0; i < NB; i++) begin
            if (w_tx_idx == 8'(i)) begin
                if (w_cur_cmd == 8'h80)
                    w_tx_byte = r_enc_sh[i*8 +: 8];
                else if (w_cur_cmd == 8'h93)
                    w_tx_byte = (i % 2 == 0) ? r_duty_sh[(i/2)*DUTY_WIDTH +: 8]
                                             : 8'(r_duty_sh[(i/2)*DUTY_WIDTH+8 +: DUTY_WIDTH-8]);
                else if ((w_cur_cmd == 8'h92) && (i < NUM_MOTORS))
                    w_tx_byte = r_hall_sh[i*8 +: 8];
            end
        end
    end

    // Shifters, command decode, register writes and strobes
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_bit_cnt     <= 3'd0;
            r_rx_sh       <= 7'd0;
            r_tx_sh       <= 8'd0;
            r_cmd         <= 8'd0;
            r_data_cnt    <= 8'd0;
            r_duty_lo     <= 8'd0;
            r_enc_sh      <= '0;
            r_hall_sh     <= '0;
            r_duty_sh     <= '0;
            r_duty        <= '0;
            r_motors_en   <= 1'b0;
            r_hall_wr     <= '0;
            r_hall_wr_val <= 8'd0;
            r_frame_done  <= 1'b0;
        end else begin
            r_hall_wr    <= '0;
            r_frame_done <= (r_state == ST_DATA) && w_ncs;
            if (w_wdt_fire) begin
                r_duty      <= '0;
                r_motors_en <= 1'b0;
            end
            if ((r_state == ST_IDLE) && w_ncs_fall) begin
                r_enc_sh   <= enc_cnt;
                r_hall_sh  <= hall_cnt;
                r_duty_sh  <= r_duty;
                r_tx_sh    <= w_status;
                r_bit_cnt  <= 3'd0;
                r_data_cnt <= 8'd0;
            end
            if (w_sck_rise) begin
                r_rx_sh   <= w_rx_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            // No shift on the fall that closes a byte: the freshly loaded MSB must stay on the pin
            if (w_sck_fall && (r_bit_cnt != 3'd0))
                r_tx_sh <= {r_tx_sh[6:0], 1'b0};
            if (w_byte_done) begin
                r_tx_sh <= w_tx_byte;
                if (r_state == ST_CMD) begin
                    r_cmd <= w_rx_byte;
                    if (w_rx_byte[6:0] == 7'h30) r_motors_en <= w_rx_byte[7];
                end else begin
                    if (r_data_cnt != 8'hFE) r_data_cnt <= r_data_cnt + 8'd1;
                    if ((r_cmd[6:0] == 7'h00) && !r_data_cnt[0]) r_duty_lo <= w_rx_byte;
                end
            end
            for (int m = 0; m < NUM_MOTORS; m++) begin
                if (w_commit && (r_data_cnt[7:1] == 7'(m)))
                    r_duty[m*DUTY_WIDTH +: DUTY_WIDTH] <= w_duty_word[DUTY_WIDTH-1:0];
                if (w_hall_en && (r_data_cnt == 8'(m))) begin
                    r_hall_wr[m]  <= 1'b1;
                    r_hall_wr_val <= w_rx_byte;
                end
            end
        end
    end

`ifdef SPI_CMD_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] r_wdt_cnt;

    assign w_wdt_fire = (r_wdt_cnt == WDT_W'(WDT_CYCLES - 1));

    // Timeout counter: restarts on each committed duty word, parks at the limit after firing once
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst)                                    r_wdt_cnt <= '0;
        else if (w_commit)                          r_wdt_cnt <= '0;
        else if (r_wdt_cnt != WDT_W'(WDT_CYCLES))   r_wdt_cnt <= r_wdt_cnt + 1'b1;
    end
`else
    // Without the counter the timeout never fires for any meaningful (positive) WDT_CYCLES
    assign w_wdt_fire = (WDT_CYCLES <= 0);
`endif

endmodule
